// File: rtl/dmem_arb_pkg.sv
// Shared sizes and arbiter state encoding for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arb_rr_pick2.sv
// Two-way combinational picker: a forced owner wins outright, otherwise a lone
// request is granted and a tie goes to the round-robin pointer.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 ptr_i,
  input  logic                 force_en_i,
  input  logic                 force_id_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (force_en_i) begin
      gnt_o = port_onehot(force_id_i) & req_i;
    end else if (&req_i) begin
      gnt_o = port_onehot(ptr_i);
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Data-memory arbiter between the core (port 0) and DMA/debug (port 1) with
// round-robin fairness, bounded burst locking and a registered read-return path.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS-1:0]          lock,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [NUM_PORTS*DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wrt_data,
  output logic                          mem_wrt,
  input  logic [DATA_W-1:0]             mem_rd_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  arb_state_e                  state_q, state_d;
  logic                        owner_q, owner_d;
  logic [CNT_W-1:0]            lock_cnt_q, lock_cnt_d;
  logic                        rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]        rvalid_q, rvalid_d;
  logic [NUM_PORTS*DATA_W-1:0] rdata_q, rdata_d;

  logic owner_hold;
  logic lock_expire;
  logic force_id;
  logic any_gnt;
  logic gnt_idx;

  // Owner keeps the bus while it holds req+lock, unless its budget is spent
  // and the other port is waiting; then the other port is forced in once.
  assign owner_hold  = (state_q == ST_LOCKED) && req[owner_q] && lock[owner_q];
  assign lock_expire = owner_hold && (lock_cnt_q == CNT_MAX) && req[~owner_q];
  assign force_id    = lock_expire ? ~owner_q : owner_q;

  rr_pick2 u_pick (
    .req_i      (req),
    .ptr_i      (rr_ptr_q),
    .force_en_i (owner_hold),
    .force_id_i (force_id),
    .gnt_o      (gnt)
  );

  assign any_gnt = |gnt;
  assign gnt_idx = gnt[1];

  always_comb begin
    mem_addr     = '0;
    mem_wrt_data = '0;
    mem_wrt      = 1'b0;
    if (any_gnt) begin
      if (gnt_idx) begin
        mem_addr     = addr[2*ADDR_W-1:ADDR_W];
        mem_wrt_data = wdata[2*DATA_W-1:DATA_W];
        mem_wrt      = we[1];
      end else begin
        mem_addr     = addr[ADDR_W-1:0];
        mem_wrt_data = wdata[DATA_W-1:0];
        mem_wrt      = we[0];
      end
    end
  end

  always_comb begin
    state_d    = ST_IDLE;
    owner_d    = owner_q;
    lock_cnt_d = '0;
    rr_ptr_d   = rr_ptr_q;
    rvalid_d   = '0;
    rdata_d    = rdata_q;

    if (any_gnt) begin
      rr_ptr_d = ~gnt_idx;
    end

    if (owner_hold && !lock_expire) begin
      state_d    = ST_LOCKED;
      lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + 4'd1;
    end else if (!lock_expire && any_gnt && lock[gnt_idx]) begin
      state_d    = ST_LOCKED;
      owner_d    = gnt_idx;
      lock_cnt_d = 4'd1;
    end

    if (any_gnt && !we[gnt_idx]) begin
      rvalid_d = gnt;
      if (gnt_idx) begin
        rdata_d[2*DATA_W-1:DATA_W] = mem_rd_data;
      end else begin
        rdata_d[DATA_W-1:0] = mem_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      lock_cnt_q <= '0;
      rr_ptr_q   <= 1'b0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: directed scenarios plus random traffic against
// a rule-level arbitration model and a reference copy of the data memory.
module tb_dmem_arb;
  import dmem_arb_pkg::*;

  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, lock;
  logic [15:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [63:0] rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wrt_data, mem_rd_data;
  logic        mem_wrt;

  dmem_arb #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .lock         (lock),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_addr     (mem_addr),
    .mem_wrt_data (mem_wrt_data),
    .mem_wrt      (mem_wrt),
    .mem_rd_data  (mem_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // data memory seen by the DUT
  logic [31:0] tb_mem [256];
  bit          tb_written [256];
  always @(posedge clk) begin
    if (mem_wrt) begin
      tb_mem[mem_addr]     <= mem_wrt_data;
      tb_written[mem_addr] <= 1'b1;
    end
  end
  assign mem_rd_data = tb_written[mem_addr] ? tb_mem[mem_addr] : init_word(mem_addr);

  typedef struct {
    int          port;
    int          due;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] hold [2];
  int          m_locked, m_owner, m_cnt, m_rr;
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  logic [1:0]  last_gnt;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endfunction

  // Arbitration rules applied to the current inputs; state committed only if upd.
  task automatic model_cycle(input bit upd);
    int g, lk, own, cnt, rr;
    logic [1:0]  eg;
    logic [7:0]  ea;
    logic [31:0] ed;
    logic        ew;
    lk = m_locked; own = m_owner; cnt = m_cnt; rr = m_rr;
    g = -1;
    if (lk == 1 && req[own] && lock[own]) begin
      if (cnt == MAX_LOCK && req[1-own]) begin
        g = 1 - own; lk = 0;
      end else begin
        g = own;
        if (cnt < MAX_LOCK) cnt++;
      end
    end else begin
      lk = 0;
      if (req == 2'b11) g = rr;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
      if (g >= 0 && lock[g]) begin
        lk = 1; own = g; cnt = 1;
      end
    end
    eg = '0; ea = '0; ed = '0; ew = 1'b0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ea = addr[8*g +: 8];
      ed = wdata[32*g +: 32];
      ew = we[g];
      rr = 1 - g;
    end
    chk("gnt", gnt, eg);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wrt_data", mem_wrt_data, ed);
    chk("mem_wrt", mem_wrt, ew);
    if (upd) begin
      m_locked = lk; m_owner = own; m_cnt = cnt; m_rr = rr;
      if (g >= 0) begin
        if (ew) ref_mem[ea] = ed;
        else exp_q.push_back('{g, cyc + 1, ref_mem[ea]});
      end
    end
  endtask

  task automatic step(input logic rst_v, input logic [1:0] r, input logic [1:0] w,
                      input logic [1:0] l, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    @(posedge clk);
    #1;
    rst = rst_v; req = r; we = w; lock = l;
    addr = {a1, a0}; wdata = {d1, d0};
    cyc++;
    if (!rst_v) begin
      m_locked = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
      #1;
      chk("rst_rvalid", rvalid, 2'b00);
      chk("rst_rdata", rdata, 64'h0);
    end
    @(negedge clk);
    last_gnt = gnt;
    model_cycle(rst_v);
  endtask

  task automatic idle(input logic rst_v);
    step(rst_v, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
  endtask

  // response monitor
  rd_exp_t     mon_e;
  logic [1:0]  mon_ev;
  logic [31:0] mon_er [2];
  always @(negedge clk) begin
    mon_ev = '0;
    if (!rst) begin
      exp_q.delete();
      hold[0] = '0;
      hold[1] = '0;
    end
    mon_er = hold;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      mon_ev[mon_e.port] = 1'b1;
      mon_er[mon_e.port] = mon_e.data;
      hold[mon_e.port]   = mon_e.data;
    end
    chk("rvalid", rvalid, mon_ev);
    chk("rdata0", rdata[31:0], mon_er[0]);
    chk("rdata1", rdata[63:32], mon_er[1]);
  end

  initial begin
    int n0, n1, first0;
    logic [1:0] rr_v, rw_v, rl_v;
    rst = 1'b0; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    m_locked = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i[7:0]);

    repeat (3) idle(1'b0);

    // write on port 0 and read of the same word on port 1 in one cycle
    step(1'b1, 2'b11, 2'b01, 2'b00, 8'h05, 8'h05, 32'hDEADBEEF, 32'h0);
    chk("wr_rd_gnt", last_gnt, 2'b01);
    step(1'b1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h05, 32'h0, 32'h0);
    chk("rd_after_wr_gnt", last_gnt, 2'b10);
    idle(1'b1);
    chk("rd_after_wr_data", rdata[63:32], 64'hDEADBEEF);

    // plain contention alternates starting at port 0
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
      chk("alt_gnt", last_gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
    end

    repeat (4) begin
      idle(1'b1);
      chk("idle_out", {gnt, mem_wrt, mem_addr, mem_wrt_data}, 64'h0);
    end

    // port 1 burst lock with port 0 waiting from cycle 2
    n1 = 0; first0 = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, {1'b1, (i >= 2)}, 2'b00, 2'b10, 8'h30, 8'h40, 32'h0, 32'h0);
      if (last_gnt == 2'b01 && first0 < 0) first0 = i;
      if (last_gnt == 2'b10 && first0 < 0) n1++;
    end
    chk("lock_hold_cnt", n1, 8);
    chk("lock_release_at", first0, 8);
    repeat (2) idle(1'b1);

    // port 0 lock with port 1 idle never expires
    n0 = 0; n1 = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 2'b01, 2'b00, 2'b01, 8'(i), 8'h00, 32'h0, 32'h0);
      if (last_gnt[0]) n0++;
      if (last_gnt[1]) n1++;
    end
    chk("sat_gnt0", n0, 30);
    chk("sat_gnt1", n1, 0);
    step(1'b1, 2'b11, 2'b00, 2'b01, 8'h01, 8'h02, 32'h0, 32'h0);
    chk("sat_expire", last_gnt, 2'b10);

    // reset in the middle of a lock with a read response pending
    repeat (3) step(1'b1, 2'b01, 2'b00, 2'b01, 8'h07, 8'h00, 32'h0, 32'h0);
    step(1'b0, 2'b11, 2'b00, 2'b00, 8'h07, 8'h08, 32'h0, 32'h0);
    idle(1'b0);
    step(1'b1, 2'b11, 2'b00, 2'b00, 8'h09, 8'h0A, 32'h0, 32'h0);
    chk("post_rst_gnt", last_gnt, 2'b01);

    // random traffic, heavy-lock phases alternate with light-lock phases
    for (int i = 0; i < 3000; i++) begin
      rr_v = {($urandom % 4) != 0, ($urandom % 4) != 0};
      rw_v = 2'($urandom);
      if ((i / 400) % 2 == 1) rl_v = {($urandom % 8) != 0, ($urandom % 8) != 0};
      else                    rl_v = {($urandom % 4) == 0, ($urandom % 4) == 0};
      if ($urandom % 600 == 0) begin
        step(1'b0, rr_v, 2'b00, rl_v, 8'($urandom % 16), 8'($urandom % 16), 32'h0, 32'h0);
      end else begin
        step(1'b1, rr_v, rw_v, rl_v, 8'($urandom % 16), 8'($urandom % 16),
             32'($urandom), 32'($urandom));
      end
    end

    repeat (3) idle(1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter SHALL be: MAX_LOCK, 8, max consecutive locked grants to one port while the other port waits (range 2..15).
REQ-002 Port SHALL be: clk  in  1  clock; all state updates on rising edge.
REQ-003 Port SHALL be: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port SHALL be: req  in  2  access request per port; bit0 = core load/store, bit1 = DMA/debug.
REQ-005 Port SHALL be: we  in  2  per-port write enable, valid with req.
REQ-006 Port SHALL be: lock  in  2  per-port burst-lock request, valid with req.
REQ-007 Port SHALL be: addr  in  16  per-port word address; port i at [8i+7:8i].
REQ-008 Port SHALL be: wdata  in  64  per-port write data; port i at [32i+31:32i].
REQ-009 Port SHALL be: gnt  out  2  one-hot-or-zero grant, combinational, same cycle as req.
REQ-010 Port SHALL be: rvalid  out  2  per-port read-data-valid pulse, registered.
REQ-011 Port SHALL be: rdata  out  64  per-port registered read data; port i at [32i+31:32i].
REQ-012 Port SHALL be: mem_addr  out  8  word address to data memory.
REQ-013 Port SHALL be: mem_wrt_data  out  32  write data to data memory.
REQ-014 Port SHALL be: mem_wrt  out  1  write strobe to data memory; memory writes on rising clk.
REQ-015 Port SHALL be: mem_rd_data  in  32  asynchronous read data from data memory.

Function
REQ-016 At most one gnt bit SHALL be high per cycle; gnt[i] high only if req[i] high.
REQ-017 One request alone SHALL be granted in the same cycle; no request -> gnt=0, mem_wrt=0, mem_addr=0, mem_wrt_data=0.
REQ-018 Granted port g SHALL drive mem_addr=addr[g], mem_wrt_data=wdata[g], mem_wrt=we[g], combinationally.
REQ-019 Both requesting, no active lock -> grant port rr_ptr; after each grant rr_ptr SHALL become the non-granted port index.
REQ-020 State SHALL be IDLE or LOCKED(owner,lock_cnt); IDLE->LOCKED when granted port has lock=1, lock_cnt=1.
REQ-021 In LOCKED, owner with req&lock SHALL be granted over the other port and lock_cnt SHALL increment (saturating at MAX_LOCK).
REQ-022 In LOCKED with lock_cnt==MAX_LOCK and other port requesting, other port SHALL be granted and state SHALL return to IDLE.
REQ-023 In LOCKED, owner deasserting req or lock SHALL return state to IDLE in that cycle's arbitration (normal round-robin applies).
REQ-024 Lock with other port idle SHALL never expire; lock_cnt stays saturated.
REQ-025 Granted read (we[g]=0) SHALL set rvalid[g]=1 for exactly the next cycle with rdata[g] = mem_rd_data captured at the grant edge.
REQ-026 rdata[i] SHALL hold its value until the next granted read on port i; writes SHALL not raise rvalid.
REQ-027 Back-to-back reads on one port SHALL yield one rvalid per grant, one cycle latency, no bubbles.

Reset
REQ-028 rst low SHALL immediately clear rvalid, rdata, lock_cnt, state to IDLE, rr_ptr to 0; combinational outputs follow req.
REQ-029 Reset during LOCKED or during a pending rvalid SHALL discard the lock and the pending response.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold NUM_PORTS=2, ADDR_W=8, DATA_W=32, and the IDLE/LOCKED state encoding.
REQ-031 Combinational two-way round-robin picker SHALL be a sub-module rr_pick2 (inputs req, ptr, forced owner; output gnt).

Verification
REQ-032 req=11, we=00, addr0=0x10, addr1=0x20, reset state -> gnt=01 then 10 alternating; rvalid one cycle after each grant with correct data.
REQ-033 Port0 write 0xDEADBEEF to 0x05 and port1 read 0x05 same cycle -> port0 granted; next cycle port1 read returns 0xDEADBEEF.
REQ-034 Port1 req=1, lock=1 for 20 cycles, port0 req=1 from cycle 2 -> port1 holds 8 grants, port0 granted next, then round-robin.
REQ-035 Port0 locked, other idle for 30 cycles -> port0 granted every cycle, lock_cnt saturated at 8, no spurious gnt[1].
REQ-036 Assert rst mid-lock with read in flight -> rvalid=0, rdata=0, rr_ptr=0 immediately; first post-reset contention grants port0.
REQ-037 req=00 for several cycles -> gnt=00, mem_wrt=0, mem_addr=0, rvalid=00.
